// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
//
// Shared definitions for the bit-serial adder slice.
//   - DefaultN   : default operand/sum width used by serial_add_ctrl
//   - St*        : FSM state encoding for serial_add_ctrl (2-bit, legacy-stable)
//   - majority() : carry function of a full adder
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int unsigned DefaultN = 8;

    // State encoding is fixed so that downstream debug tooling can decode it.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StAdd  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
//
// One-bit full adder with a carry flop, the arithmetic core of the bit-serial
// adder. The sum bit is combinational (Mealy) on the current operand bits and
// the stored carry.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset, clears the carry
//   i_a, i_b       operand bits for this cycle
//   i_clr          synchronous carry clear (wins over i_en)
//   i_en           capture the next carry at the clock edge
//   o_sum          i_a ^ i_b ^ carry
//   o_carry_next   carry that will be stored if i_en is high
// -----------------------------------------------------------------------------
module serial_fa_cell
    import serial_add_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_a,
    input  logic i_b,
    input  logic i_clr,
    input  logic i_en,
    output logic o_sum,
    output logic o_carry_next
);

    logic r_carry;
    logic w_carry_next;

    assign w_carry_next = majority(i_a, i_b, r_carry);
    assign o_sum        = i_a ^ i_b ^ r_carry;
    assign o_carry_next = w_carry_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_carry <= 1'b0;
        end else if (i_clr) begin
            r_carry <= 1'b0;
        end else if (i_en) begin
            r_carry <= w_carry_next;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Control and sum stage of the bit-serial adder. Sequences the two external
// operand shift registers (one load cycle, then N shift cycles), adds their
// LSBs one bit per cycle and assembles the N-bit sum LSB-first in an internal
// shift register. A one-cycle done pulse marks o_sum/o_cout valid.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_start    request an addition; only honoured in IDLE or DONE
//   i_a_bit    LSB of operand register A
//   i_b_bit    LSB of operand register B
//   o_ld       load strobe to both operand registers (LOAD)
//   o_shift    shift strobe to both operand registers (ADD)
//   o_sum_bit  combinational sum bit of the current cycle (debug)
//   o_sum      accumulated N-bit sum, stable outside ADD
//   o_cout     final carry-out, valid with o_sum
//   o_busy     high in LOAD and ADD
//   o_done     one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned N = DefaultN  // must be >= 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_a_bit,
    input  logic         i_b_bit,
    output logic         o_ld,
    output logic         o_shift,
    output logic         o_sum_bit,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_busy,
    output logic         o_done
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LastCount = CNT_W'(N - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [N-1:0]     r_sum;
    logic             r_cout;

    logic w_in_load;
    logic w_in_add;
    logic w_last;
    logic w_sum_bit;
    logic w_carry_next;

    assign w_in_load = (r_state == StLoad);
    assign w_in_add  = (r_state == StAdd);
    assign w_last    = w_in_add && (r_count == LastCount);

    // -------------------------------------------------------------------------
    // Arithmetic: carry is cleared while loading so a previous carry-out never
    // leaks into a back-to-back addition.
    // -------------------------------------------------------------------------
    serial_fa_cell u_fa (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_a          (i_a_bit),
        .i_b          (i_b_bit),
        .i_clr        (w_in_load),
        .i_en         (w_in_add),
        .o_sum        (w_sum_bit),
        .o_carry_next (w_carry_next)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StLoad;
            StLoad:  w_state_next = StAdd;
            StAdd:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = i_start ? StLoad : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Bit counter and sum register. The counter returns to zero on the last
    // ADD edge instead of reaching N, so it never leaves 0..N-1.
    // The sum fills from the MSB end: after N shifts bit 0 of the operands
    // has reached o_sum[0].
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_in_load) begin
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_in_add) begin
            r_sum <= {w_sum_bit, r_sum[N-1:1]};
            if (w_last) begin
                r_count <= '0;
                r_cout  <= w_carry_next;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: Moore decode of the state, except the debug sum bit.
    // -------------------------------------------------------------------------
    assign o_ld      = w_in_load;
    assign o_shift   = w_in_add;
    assign o_busy    = w_in_load | w_in_add;
    assign o_done    = (r_state == StDone);
    assign o_sum_bit = w_sum_bit;
    assign o_sum     = r_sum;
    assign o_cout    = r_cout;

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_count_range: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) r_count <= LastCount
    );

    a_strobes_exclusive: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(o_ld && o_shift)
    );

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;

    // N = 8 instance and its operand registers
    logic       start;
    logic [7:0] op_a, op_b, a_q, b_q;
    logic       ld, shift, sum_bit, cout, busy, done;
    logic [7:0] sum;

    // N = 4 instance and its operand registers
    logic       start4;
    logic [3:0] op_a4, op_b4, a4_q, b4_q;
    logic       ld4, shift4, sum_bit4, cout4, busy4, done4;
    logic [3:0] sum4;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl #(.N(8)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_a_bit   (a_q[0]),
        .i_b_bit   (b_q[0]),
        .o_ld      (ld),
        .o_shift   (shift),
        .o_sum_bit (sum_bit),
        .o_sum     (sum),
        .o_cout    (cout),
        .o_busy    (busy),
        .o_done    (done)
    );

    serial_add_ctrl #(.N(4)) dut4 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start4),
        .i_a_bit   (a4_q[0]),
        .i_b_bit   (b4_q[0]),
        .o_ld      (ld4),
        .o_shift   (shift4),
        .o_sum_bit (sum_bit4),
        .o_sum     (sum4),
        .o_cout    (cout4),
        .o_busy    (busy4),
        .o_done    (done4)
    );

    // Operand shift registers: load, shift right, otherwise clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0; b_q <= '0; a4_q <= '0; b4_q <= '0;
        end else begin
            if (ld) begin a_q <= op_a; b_q <= op_b; end
            else if (shift) begin a_q <= a_q >> 1; b_q <= b_q >> 1; end
            else begin a_q <= '0; b_q <= '0; end
            if (ld4) begin a4_q <= op_a4; b4_q <= op_b4; end
            else if (shift4) begin a4_q <= a4_q >> 1; b4_q <= b4_q >> 1; end
            else begin a4_q <= '0; b4_q <= '0; end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
    endtask

    // Observes one N=8 addition after i_start was sampled. Reference: the sum
    // is (a+b) mod 256, the carry is bit 8 of a+b, and sum bit i appears in
    // the i-th shift cycle. Optionally pulses i_start in the 3rd ADD cycle,
    // chains a new addition from DONE, or resets in the given ADD cycle.
    task automatic collect8(input logic [7:0] a, input logic [7:0] b, input bit glitch,
                            input bit chain, input logic [7:0] na, input logic [7:0] nb,
                            input int abort_at);
        int         ld_n, sh_n, busy_n, done_n, done_k;
        logic [8:0] total;
        logic [7:0] bits;
        total  = {1'b0, a} + {1'b0, b};
        bits   = '0;
        ld_n   = 0; sh_n = 0; busy_n = 0; done_n = 0; done_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ld) ld_n++;
            if (busy) busy_n++;
            if (shift) begin
                if (sh_n < 8) bits[sh_n] = sum_bit;
                sh_n++;
                if (glitch && sh_n == 3) start = 1'b1;
                if (abort_at != 0 && sh_n == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq("rst_async_ld", 32'(ld), 32'd0);
                    check_eq("rst_async_shift", 32'(shift), 32'd0);
                    check_eq("rst_async_busy", 32'(busy), 32'd0);
                    check_eq("rst_async_done", 32'(done), 32'd0);
                    check_eq("rst_async_sum", 32'(sum), 32'd0);
                    check_eq("rst_async_cout", 32'(cout), 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    check_eq("rst_idle_busy", 32'(busy), 32'd0);
                    check_eq("rst_idle_ld", 32'(ld), 32'd0);
                    return;
                end
            end
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    check_eq("latency_edges", 32'(k), 32'd10);
                    check_eq("ld_cycles", 32'(ld_n), 32'd1);
                    check_eq("shift_cycles", 32'(sh_n), 32'd8);
                    check_eq("busy_cycles", 32'(busy_n), 32'd9);
                    check_eq("sum", 32'(sum), 32'(total[7:0]));
                    check_eq("cout", 32'(cout), 32'(total[8]));
                    check_eq("sum_bits", 32'(bits), 32'(total[7:0]));
                    if (chain) begin
                        op_a  = na;
                        op_b  = nb;
                        start = 1'b1;
                        return;
                    end
                end
            end
            if (done_k > 0 && k >= done_k + 12) break;
        end
        check_eq("done_seen", 32'(done_k > 0), 32'd1);
        check_eq("done_count", 32'(done_n), 32'd1);
        check_eq("sum_hold", 32'(sum), 32'(total[7:0]));
        check_eq("cout_hold", 32'(cout), 32'(total[8]));
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        int         done_n, done_k, sh_n;
        logic [4:0] total;
        logic [3:0] bits;
        total = {1'b0, a} + {1'b0, b};
        bits  = '0;
        done_n = 0; done_k = -1; sh_n = 0;
        @(negedge clk);
        op_a4  = a;
        op_b4  = b;
        start4 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (shift4) begin
                if (sh_n < 4) bits[sh_n] = sum_bit4;
                sh_n++;
            end
            if (done4) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    check_eq("n4_latency", 32'(k), 32'd6);
                    check_eq("n4_sum", 32'(sum4), 32'(total[3:0]));
                    check_eq("n4_cout", 32'(cout4), 32'(total[4]));
                    check_eq("n4_sum_bits", 32'(bits), 32'(total[3:0]));
                    check_eq("n4_busy_low", 32'(busy4), 32'd0);
                end
            end
            if (done_k > 0 && k >= done_k + 4) break;
        end
        check_eq("n4_done_count", 32'(done_n), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb, rc, rd;
        checks   = 0;
        failures = 0;
        rst_n  = 1'b0;
        start  = 1'b0; op_a  = '0; op_b  = '0;
        start4 = 1'b0; op_a4 = '0; op_b4 = '0;
        #1;
        check_eq("reset_ld", 32'(ld), 32'd0);
        check_eq("reset_shift", 32'(shift), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_sum", 32'(sum), 32'd0);
        check_eq("reset_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_no_start", 32'(busy), 32'd0);

        launch8(8'h5A, 8'h3C);
        collect8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 0);

        launch8(8'hFF, 8'h01);
        collect8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 0);

        // Back-to-back: second LOAD directly out of DONE, carry must be cleared.
        launch8(8'hFF, 8'hFF);
        collect8(8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h00, 0);
        collect8(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0);

        // i_start during ADD must be ignored.
        launch8(8'h12, 8'h34);
        collect8(8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 8'h00, 0);

        // Reset in the 5th ADD cycle, then a fresh addition.
        launch8(8'hAA, 8'h55);
        collect8(8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, 5);
        launch8(8'h01, 8'h02);
        collect8(8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            launch8(ra, rb);
            collect8(ra, rb, 1'b0, 1'b0, 8'h00, 8'h00, 0);
        end

        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 8'($urandom_range(0, 255));
        rd = 8'($urandom_range(0, 255));
        launch8(ra, rb);
        collect8(ra, rb, 1'b0, 1'b1, rc, rd, 0);
        collect8(rc, rd, 1'b0, 1'b0, 8'h00, 8'h00, 0);

        run4(4'hF, 4'h1);
        for (int i = 0; i < 4; i++) begin
            run4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
